mem_req_demux: RTL and testbench
================================

# mem_req_demux

Routes one upstream memory request channel (the core's load/store port) to one of two downstream targets: port 0 (data RAM) or port 1 (MMIO), chosen by address. It returns the selected target's response upstream and supports one outstanding transaction. A timeout returns an error response when a target never answers, so an unmapped or hung target cannot stall the core.

## Interface
Parameters:
- BUS_WIDTH, 32: data width.
- ADDR_WIDTH, 32: address width.
- SEL_BASE, 32'h8000_0000: addresses >= SEL_BASE (unsigned) go to port 1, others to port 0.
- TIMEOUT, 16: cycles allowed in REQ+WAIT before an error response; legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on timeout.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- up_valid  in  1  upstream request valid.
- up_ready  out  1  upstream request accepted when up_valid && up_ready.
- up_addr  in  ADDR_WIDTH  request address.
- up_wdata  in  BUS_WIDTH  write data.
- up_we  in  1  1 = write, 0 = read.
- up_rsp_valid  out  1  one-cycle response pulse.
- up_rsp_rdata  out  BUS_WIDTH  read data; 0 for writes; ERR_DATA on timeout.
- up_rsp_err  out  1  1 = timeout, qualified by up_rsp_valid.
- dn_addr  out  ADDR_WIDTH  latched address, shared by both ports.
- dn_wdata  out  BUS_WIDTH  latched write data, shared.
- dn_we  out  1  latched write enable, shared.
- p0_valid / p1_valid  out  1  request valid to port 0 / port 1.
- p0_ready / p1_ready  in  1  target accepts the request.
- p0_rsp_valid / p1_rsp_valid  in  1  target response pulse.
- p0_rsp_rdata / p1_rsp_rdata  in  BUS_WIDTH  target read data.

## Operation
- FSM states are IDLE, REQ and WAIT. Registers are sel, the latched addr/wdata/we, timer, and the response registers.
- up_ready = (state == IDLE) && !rst.
- IDLE: on up_valid, latch addr/wdata/we, set sel = (up_addr >= SEL_BASE), clear timer, go to REQ. Otherwise stay in IDLE.
- REQ: p<sel>_valid = 1 and the other valid = 0. dn_* hold the latched values, which are stable until the transaction ends. On p<sel>_ready, go to WAIT. The non-selected port's ready is ignored.
- WAIT: sample only p<sel>_rsp_valid; the other port's responses are ignored.
  - On response: register up_rsp_rdata = (we ? 0 : p<sel>_rsp_rdata) and up_rsp_err = 0, pulse up_rsp_valid, go to IDLE.
- Timer increments every cycle in REQ and WAIT. If the TIMEOUT-th cycle ends with no completing response (including a target still not ready in REQ), pulse up_rsp_valid with err = 1 and rdata = ERR_DATA, and go to IDLE.
  - In the abandoned case p<sel>_valid drops, and a late response is ignored.
- Response arriving in the same cycle as the timeout condition: the response wins (err = 0).
- rsp_valid asserted in REQ, including the acceptance cycle, is ignored. Targets must respond no earlier than the cycle after acceptance.
- dn_* outputs in IDLE: hold their last values (don't-care to targets).

## Timing
- Reset values: state IDLE, p0_valid = p1_valid = 0, up_rsp_valid = 0, up_rsp_err = 0, up_rsp_rdata = 0, dn_* = 0, timer = 0. up_ready = 0 while rst is high and 1 from the first cycle after rst deasserts.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and p<sel>_valid is 0 from the cycle after the reset edge.
- Minimum latency: accept at cycle N, p<sel>_valid high at N+1, ready at N+1, rsp_valid at N+2, up_rsp_valid at N+3.
- up_ready = 1 again at N+3, so back-to-back throughput is one transaction per 3 cycles minimum.
- up_rsp_valid is exactly one cycle wide and never asserted two cycles in a row.
- p<sel>_valid stays high from REQ entry until ready or timeout; it never deasserts otherwise.

## Test plan
- Read to port 0: up_addr = 0x0000_0100, p0_ready same cycle, p0_rsp_rdata = 0x1234_5678 one cycle later -> up_rsp_valid at N+3, rdata = 0x1234_5678, err = 0; p1_valid stays 0.
- Write to port 1 at the boundary: up_addr = 0x8000_0000, wdata = 0xA5A5_A5A5, we = 1 -> p1_valid with dn_wdata = 0xA5A5_A5A5; after p1_rsp_valid, rdata = 0 and err = 0. Repeat with 0x7FFF_FFFC -> routes to port 0.
- Backpressure: p0_ready held low 5 cycles (TIMEOUT = 16) -> p0_valid and dn_* stable all 5 cycles, up_ready = 0, normal response afterwards.
- Timeout: TIMEOUT = 8, target accepts but never responds -> up_rsp_valid 8 cycles after REQ entry, err = 1, rdata = 0xDEAD_BEEF. A late p0_rsp_valid afterwards produces no second response.
- Stray response: p1_rsp_valid pulsed while a port-0 read is in WAIT -> ignored; the port-0 response completes normally.
- Reset in WAIT: rst high for 1 cycle -> no up_rsp_valid, p0_valid = p1_valid = 0, and the next request completes normally.

Source files
------------

// File: rtl/mem_req_demux.sv
// mem_req_demux: routes a single upstream memory request to the data RAM
// (port 0) or to MMIO (port 1), selected by address. Only one transaction
// is outstanding at a time. A cycle timer turns a silent target into an
// error response, so the core cannot stall on it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; up_ready high, dn_* hold their last values
// REQ   | p<sel>_valid high, waiting for the selected target to accept
// WAIT  | request accepted, waiting for the selected target's response
module mem_req_demux #(
    parameter int                    BUS_WIDTH  = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] SEL_BASE   = 32'h8000_0000,
    parameter int                    TIMEOUT    = 16,
    parameter logic [BUS_WIDTH-1:0]  ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [ADDR_WIDTH-1:0] up_addr,
    input  logic [BUS_WIDTH-1:0]  up_wdata,
    input  logic                  up_we,
    output logic                  up_rsp_valid,
    output logic [BUS_WIDTH-1:0]  up_rsp_rdata,
    output logic                  up_rsp_err,
    output logic [ADDR_WIDTH-1:0] dn_addr,
    output logic [BUS_WIDTH-1:0]  dn_wdata,
    output logic                  dn_we,
    output logic                  p0_valid,
    input  logic                  p0_ready,
    input  logic                  p0_rsp_valid,
    input  logic [BUS_WIDTH-1:0]  p0_rsp_rdata,
    output logic                  p1_valid,
    input  logic                  p1_ready,
    input  logic                  p1_rsp_valid,
    input  logic [BUS_WIDTH-1:0]  p1_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Timer holds the number of REQ+WAIT cycles already completed, so the
    // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t               state;
    logic                 sel;
    logic [7:0]           timer;

    logic                 tgt_ready;
    logic                 tgt_rsp_valid;
    logic [BUS_WIDTH-1:0] tgt_rsp_rdata;
    logic                 timer_expired;

    // Only the selected target is ever looked at; the other port is ignored.
    assign tgt_ready     = sel ? p1_ready     : p0_ready;
    assign tgt_rsp_valid = sel ? p1_rsp_valid : p0_rsp_valid;
    assign tgt_rsp_rdata = sel ? p1_rsp_rdata : p0_rsp_rdata;
    assign timer_expired = (timer == TIMER_LAST);

    assign up_ready = (state == S_IDLE) && !rst;

    // Request/response sequencing, timeout, and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sel          <= 1'b0;
            timer        <= '0;
            dn_addr      <= '0;
            dn_wdata     <= '0;
            dn_we        <= 1'b0;
            p0_valid     <= 1'b0;
            p1_valid     <= 1'b0;
            up_rsp_valid <= 1'b0;
            up_rsp_err   <= 1'b0;
            up_rsp_rdata <= '0;
        end else begin
            up_rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (up_valid) begin
                        dn_addr  <= up_addr;
                        dn_wdata <= up_wdata;
                        dn_we    <= up_we;
                        sel      <= (up_addr >= SEL_BASE);
                        p0_valid <= (up_addr <  SEL_BASE);
                        p1_valid <= (up_addr >= SEL_BASE);
                        timer    <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A target accepting on the last allowed cycle still has
                    // no response, so expiry takes priority over ready here.
                    if (timer_expired) begin
                        p0_valid     <= 1'b0;
                        p1_valid     <= 1'b0;
                        up_rsp_valid <= 1'b1;
                        up_rsp_err   <= 1'b1;
                        up_rsp_rdata <= ERR_DATA;
                        state        <= S_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                        if (tgt_ready) begin
                            p0_valid <= 1'b0;
                            p1_valid <= 1'b0;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A response on the expiring cycle still counts as success.
                    if (tgt_rsp_valid) begin
                        up_rsp_valid <= 1'b1;
                        up_rsp_err   <= 1'b0;
                        up_rsp_rdata <= dn_we ? '0 : tgt_rsp_rdata;
                        state        <= S_IDLE;
                    end else if (timer_expired) begin
                        up_rsp_valid <= 1'b1;
                        up_rsp_err   <= 1'b1;
                        up_rsp_rdata <= ERR_DATA;
                        state        <= S_IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    p0_valid <= 1'b0;
                    p1_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_demux.sv
// Bench for mem_req_demux: directed transactions, a transaction-level
// reference model compared every cycle, and literal latency/data checks.
module tb_mem_req_demux;

    localparam int          TMO  = 8;
    localparam logic [31:0] SEL  = 32'h8000_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [31:0] up_addr = '0;
    logic [31:0] up_wdata = '0;
    logic        up_we = 1'b0;
    logic        up_rsp_valid;
    logic [31:0] up_rsp_rdata;
    logic        up_rsp_err;
    logic [31:0] dn_addr;
    logic [31:0] dn_wdata;
    logic        dn_we;
    logic        p0_valid, p1_valid;
    logic [1:0]  rdy  = '0;
    logic [1:0]  rspv = '0;
    logic [31:0] rd0 = '0, rd1 = '0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_req_demux #(
        .BUS_WIDTH(32), .ADDR_WIDTH(32), .SEL_BASE(SEL),
        .TIMEOUT(TMO), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready),
        .up_addr(up_addr), .up_wdata(up_wdata), .up_we(up_we),
        .up_rsp_valid(up_rsp_valid), .up_rsp_rdata(up_rsp_rdata),
        .up_rsp_err(up_rsp_err),
        .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_we(dn_we),
        .p0_valid(p0_valid), .p0_ready(rdy[0]),
        .p0_rsp_valid(rspv[0]), .p0_rsp_rdata(rd0),
        .p1_valid(p1_valid), .p1_ready(rdy[1]),
        .p1_rsp_valid(rspv[1]), .p1_rsp_rdata(rd1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one open transaction with its age in cycles.
    bit          started = 0;
    bit          m_busy = 0, m_acc = 0, m_port = 0, m_we = 0;
    int          m_age = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    bit          m_rsp_v = 0, m_rsp_err = 0;
    logic [31:0] m_rsp_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_busy = 0; m_acc = 0; m_port = 0; m_age = 0;
            m_we = 0; m_addr = '0; m_wdata = '0;
            m_rsp_v = 0; m_rsp_err = 0; m_rsp_data = '0;
        end else begin
            m_rsp_v = 0;
            if (!m_busy) begin
                if (up_valid) begin
                    m_busy = 1; m_acc = 0; m_age = 0;
                    m_addr = up_addr; m_wdata = up_wdata; m_we = up_we;
                    m_port = (up_addr >= SEL);
                end
            end else begin
                m_age++;
                if (m_acc && rspv[m_port]) begin
                    m_busy = 0; m_rsp_v = 1; m_rsp_err = 0;
                    m_rsp_data = m_we ? 32'h0 : (m_port ? rd1 : rd0);
                end else if (m_age == TMO) begin
                    m_busy = 0; m_rsp_v = 1; m_rsp_err = 1; m_rsp_data = ERRD;
                end else if (!m_acc && rdy[m_port]) begin
                    m_acc = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("up_ready", up_ready, !m_busy && !rst);
            chk("p0_valid", p0_valid, m_busy && !m_acc && !m_port);
            chk("p1_valid", p1_valid, m_busy && !m_acc && m_port);
            chk("up_rsp_valid", up_rsp_valid, m_rsp_v);
            chk("dn_addr", dn_addr, m_addr);
            chk("dn_wdata", dn_wdata, m_wdata);
            chk("dn_we", dn_we, m_we);
            if (m_rsp_v) begin
                chk("up_rsp_rdata", up_rsp_rdata, m_rsp_data);
                chk("up_rsp_err", up_rsp_err, m_rsp_err);
            end
        end
    end

    // Issues one request and drives the selected target: ready rdy_dly
    // cycles after REQ entry, response rsp_dly cycles after acceptance
    // (negative = never). The other port pulses ready+response at stray_cyc.
    // lat is measured from the accept cycle N (3 = minimum).
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd,
                           input logic we, input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rdv, input int stray_cyc,
                           input bit early, output int lat,
                           output logic [31:0] got_d, output logic got_e);
        int port;
        port = (addr >= SEL) ? 1 : 0;
        lat = -1; got_d = '0; got_e = 1'b0;
        up_valid = 1'b1; up_addr = addr; up_wdata = wd; up_we = we;
        step();
        up_valid = 1'b0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            rdy = '0; rspv = '0;
            if (c == rdy_dly) rdy[port] = 1'b1;
            if (rsp_dly >= 0 && c == rdy_dly + 1 + rsp_dly) rspv[port] = 1'b1;
            if (early && c == rdy_dly) rspv[port] = 1'b1;
            if (c == stray_cyc) begin
                rdy[1-port] = 1'b1;
                rspv[1-port] = 1'b1;
            end
            rd0 = port ? ~rdv : rdv;
            rd1 = port ? rdv : ~rdv;
            step();
            if (up_rsp_valid) begin
                lat = c + 2;
                got_d = up_rsp_rdata;
                got_e = up_rsp_err;
            end
        end
        rdy = '0; rspv = '0;
        if (lat < 0) chk("rsp_within_bound", up_rsp_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] d;
        logic        e;

        // reset
        step(); step();
        chk("rst_up_ready", up_ready, 1'b0);
        chk("rst_p0_valid", p0_valid, 1'b0);
        chk("rst_rsp_rdata", up_rsp_rdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_up_ready", up_ready, 1'b1);
        step();

        // read to port 0, minimum latency
        run_txn(32'h0000_0100, 32'h0, 1'b0, 0, 0, 32'h1234_5678, -1, 0, lat, d, e);
        chk("rd_p0_lat", lat, 3);
        chk("rd_p0_rdata", d, 32'h1234_5678);
        chk("rd_p0_err", e, 1'b0);
        chk("rd_p0_up_ready", up_ready, 1'b1);

        // write to port 1 at the boundary, back-to-back
        run_txn(32'h8000_0000, 32'hA5A5_A5A5, 1'b1, 0, 0, 32'hFFFF_0000, -1, 0, lat, d, e);
        chk("wr_p1_lat", lat, 3);
        chk("wr_p1_rdata", d, 32'h0);
        chk("wr_p1_err", e, 1'b0);

        // just below the boundary goes to port 0
        run_txn(32'h7FFF_FFFC, 32'h0102_0304, 1'b1, 0, 1, 32'h5555_AAAA, -1, 0, lat, d, e);
        chk("wr_p0_lat", lat, 4);
        chk("wr_p0_rdata", d, 32'h0);

        // backpressure 5 cycles, with a stray port-1 pulse during REQ
        run_txn(32'h0000_0040, 32'h0, 1'b0, 5, 0, 32'hCAFE_0001, 2, 0, lat, d, e);
        chk("bp_lat", lat, 8);
        chk("bp_rdata", d, 32'hCAFE_0001);

        // timeout: accepted, never answers
        run_txn(32'h0000_0080, 32'h0, 1'b0, 0, -1, 32'h0, -1, 0, lat, d, e);
        chk("tmo_lat", lat, 9);
        chk("tmo_rdata", d, 32'hDEAD_BEEF);
        chk("tmo_err", e, 1'b1);
        rspv[0] = 1'b1; rd0 = 32'h1111_1111;
        step();
        rspv[0] = 1'b0;
        step();
        chk("late_rsp_ignored", up_rsp_valid, 1'b0);

        // stray port-1 response while port-0 read is in WAIT
        run_txn(32'h0000_0200, 32'h0, 1'b0, 0, 2, 32'h0BAD_F00D, 1, 0, lat, d, e);
        chk("stray_lat", lat, 5);
        chk("stray_rdata", d, 32'h0BAD_F00D);

        // response on the last allowed cycle wins over timeout
        run_txn(32'h9000_0000, 32'h0, 1'b0, 0, 6, 32'h7777_0008, -1, 0, lat, d, e);
        chk("edge_rsp_lat", lat, 9);
        chk("edge_rsp_err", e, 1'b0);
        chk("edge_rsp_rdata", d, 32'h7777_0008);

        // ready only on the last allowed cycle: still a timeout
        run_txn(32'h0000_0300, 32'h0, 1'b0, 7, 0, 32'h0, -1, 0, lat, d, e);
        chk("edge_rdy_lat", lat, 9);
        chk("edge_rdy_err", e, 1'b1);

        // response in the acceptance cycle is ignored
        run_txn(32'h8000_0010, 32'h0, 1'b0, 2, 1, 32'h2468_ACE0, -1, 1, lat, d, e);
        chk("early_lat", lat, 6);
        chk("early_rdata", d, 32'h2468_ACE0);

        // reset while in WAIT
        step();
        up_valid = 1'b1; up_addr = 32'h0000_0400; up_we = 1'b0;
        step();
        up_valid = 1'b0; rdy[0] = 1'b1;
        step();
        rdy[0] = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait_p0_valid", p0_valid, 1'b0);
        chk("rst_wait_p1_valid", p1_valid, 1'b0);
        chk("rst_wait_rsp", up_rsp_valid, 1'b0);
        rspv[0] = 1'b1;
        step();
        rspv[0] = 1'b0;
        chk("rst_wait_no_rsp", up_rsp_valid, 1'b0);
        run_txn(32'h0000_0500, 32'h0, 1'b0, 1, 0, 32'h0F0F_0F0F, -1, 0, lat, d, e);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_rdata", d, 32'h0F0F_0F0F);

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
